// File: rtl/ch3_wave_gen.sv
// ch3_wave_gen: wave channel sequencer with length counter and volume shift.
// Ports: cery_2mhz/napu_reset, ff1a..ff1e register bits, trig, len_tick,
//   wave_addr/wave_data (RAM), sample_out, ch3_active, nfreq_cnt.
// Build option: CH3_FREQ_READBACK_EN drives nfreq_cnt with ~freq_cnt.
module ch3_wave_gen #(
  parameter int LEN_BITS = 8
) (
  input  logic        cery_2mhz,
  input  logic        napu_reset,
  input  logic        ff1a_d7,
  input  logic [7:0]  ff1b_d,
  input  logic        ff1b_wr,
  input  logic        ff1c_d5,
  input  logic        ff1c_d6,
  input  logic [7:0]  ff1d_d,
  input  logic [2:0]  ff1e_d,
  input  logic        ff1e_d6,
  input  logic        trig,
  input  logic        len_tick,
  output logic [3:0]  wave_addr,
  input  logic [7:0]  wave_data,
  output logic [3:0]  sample_out,
  output logic        ch3_active,
  output logic [10:0] nfreq_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    PLAY
  } state_t;

  state_t              state;
  logic [10:0]         freq_cnt;
  logic [4:0]          pos;
  logic [7:0]          wave_buf;
  logic                buf_ld;
  logic [LEN_BITS-1:0] len_cnt;

  logic [10:0]         freq_ld;
  logic                adv;
  logic                len_inc;
  logic                len_exp;
  logic                go;
  logic [3:0]          nibble;

  always_comb begin
    freq_ld = {ff1e_d, ff1d_d};
    adv     = (state == PLAY) && (freq_cnt == 11'h7FF);
    // a register write on the same cycle suppresses the tick
    len_inc = len_tick && ff1e_d6 && !ff1b_wr;
    len_exp = len_inc && (&len_cnt) && (state == PLAY);
    go      = trig && ff1a_d7;
  end

  always_ff @(posedge cery_2mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      state    <= IDLE;
      freq_cnt <= '0;
      pos      <= '0;
      wave_buf <= '0;
      buf_ld   <= 1'b0;
      len_cnt  <= '0;
    end else begin
      buf_ld <= 1'b0;
      // RAM address settled one cycle after pos moved
      if (buf_ld)
        wave_buf <= wave_data;
      if (ff1b_wr)
        len_cnt <= LEN_BITS'(ff1b_d);
      else if (len_inc)
        len_cnt <= len_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (go)
            state <= START;
        end
        START: begin
          freq_cnt <= freq_ld;
          pos      <= '0;
          buf_ld   <= 1'b1;
          state    <= PLAY;
        end
        PLAY: begin
          if (adv) begin
            freq_cnt <= freq_ld;
            pos      <= pos + 1'b1;
            buf_ld   <= 1'b1;
          end else begin
            freq_cnt <= freq_cnt + 1'b1;
          end
          // retrigger outranks length expiry
          if (go)
            state <= START;
          else if (!ff1a_d7 || len_exp)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wave_addr  = pos[4:1];
  assign ch3_active = (state != IDLE);
  assign nibble     = pos[0] ? wave_buf[3:0] : wave_buf[7:4];

  always_comb begin
    sample_out = 4'h0;
    if (ch3_active) begin
      case ({ff1c_d6, ff1c_d5})
        2'b01:   sample_out = nibble;
        2'b10:   sample_out = nibble >> 1;
        2'b11:   sample_out = nibble >> 2;
        default: sample_out = 4'h0;
      endcase
    end
  end

`ifdef CH3_FREQ_READBACK_EN
  assign nfreq_cnt = ~freq_cnt;
`else
  assign nfreq_cnt = 11'h7FF;
`endif

endmodule

// File: tb/tb_ch3_wave_gen.sv
// tb_ch3_wave_gen: directed checks for ch3_wave_gen.
// Drives register bits and a wave RAM model; checks outputs.
module tb_ch3_wave_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dac;
  logic [7:0]  ff1b_d;
  logic        ff1b_wr;
  logic        d5, d6;
  logic [7:0]  ff1d_d;
  logic [2:0]  ff1e_d;
  logic        len_en;
  logic        trig;
  logic        len_tick;
  logic [3:0]  wave_addr;
  logic [7:0]  wave_data;
  logic [3:0]  sample_out;
  logic        ch3_active;
  logic [10:0] nfreq_cnt;

  logic [7:0]  mem [16];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign wave_data = mem[wave_addr];

  ch3_wave_gen #(.LEN_BITS(8)) dut (
    .cery_2mhz  (clk),
    .napu_reset (rst_n),
    .ff1a_d7    (dac),
    .ff1b_d     (ff1b_d),
    .ff1b_wr    (ff1b_wr),
    .ff1c_d5    (d5),
    .ff1c_d6    (d6),
    .ff1d_d     (ff1d_d),
    .ff1e_d     (ff1e_d),
    .ff1e_d6    (len_en),
    .trig       (trig),
    .len_tick   (len_tick),
    .wave_addr  (wave_addr),
    .wave_data  (wave_data),
    .sample_out (sample_out),
    .ch3_active (ch3_active),
    .nfreq_cnt  (nfreq_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] vol_exp [4];
  logic [10:0] nf_exp;
  int n;

  initial begin
    rst_n = 1'b0; dac = 0; ff1b_d = 0; ff1b_wr = 0;
    d5 = 0; d6 = 0; ff1d_d = 0; ff1e_d = 0; len_en = 0;
    trig = 0; len_tick = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 8'h11);
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;

    #3;
    check("rst_active", ch3_active, 0);
    check("rst_sample", sample_out, 0);
    check("rst_addr", wave_addr, 0);
    check("rst_nfreq", nfreq_cnt, 11'h7FF);
    step(); step();
    rst_n = 1'b1;
    step();

    trig = 1; step(); trig = 0;
    check("trig_no_dac", ch3_active, 0);

    dac = 1; d5 = 1; d6 = 0;
    ff1d_d = 8'hFE; ff1e_d = 3'h7;
    trig = 1; step(); trig = 0;
    check("start_active", ch3_active, 1);
    step();
    check("e1_addr", wave_addr, 0);
    check("e1_sample", sample_out, 0);
    step();
    check("e2_sample", sample_out, 4'hA);
`ifdef CH3_FREQ_READBACK_EN
    nf_exp = 11'h000;
`else
    nf_exp = 11'h7FF;
`endif
    check("e2_nfreq", nfreq_cnt, nf_exp);
    step();
    check("e3_sample", sample_out, 4'h5);
    check("e3_addr", wave_addr, 0);
    step(); step();
    check("e5_addr", wave_addr, 1);
    check("e5_sample", sample_out, 4'hA);
    step();
    check("e6_sample", sample_out, 4'h3);
    step();
    check("e7_sample", sample_out, 4'hC);
    repeat (56) step();
    check("e63_addr", wave_addr, 15);
    step(); step();
    check("wrap_addr", wave_addr, 0);

    dac = 0; step();
    check("dac_off_active", ch3_active, 0);
    check("dac_off_sample", sample_out, 0);

    for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
    ff1d_d = 8'h00; ff1e_d = 3'h0; dac = 1;
    trig = 1; step(); trig = 0;
    step(); step();
    vol_exp[0] = 4'h0; vol_exp[1] = 4'hF;
    vol_exp[2] = 4'h7; vol_exp[3] = 4'h3;
    for (int v = 0; v < 4; v++) begin
      {d6, d5} = 2'(v);
      #1;
      check($sformatf("vol%0d", v), sample_out, vol_exp[v]);
    end
    d6 = 0; d5 = 1;

    n = 2;
    while (wave_addr != 4'd1 && n < 5000) begin
      step(); n++;
    end
    check("first_adv2", n, 4097);
    n = 0;
    while (wave_addr != 4'd2 && n < 5000) begin
      step(); n++;
    end
    check("period_x2", n, 4096);

    dac = 0; step();
    ff1d_d = 8'hFE; ff1e_d = 3'h7;
    ff1b_d = 8'hFE; ff1b_wr = 1; step(); ff1b_wr = 0;
    len_en = 1; dac = 1;
    trig = 1; step(); trig = 0;
    step();
    len_tick = 1; step(); len_tick = 0;
    check("len_ff_active", ch3_active, 1);
    step();
    len_tick = 1; step(); len_tick = 0;
    check("len_exp_active", ch3_active, 0);
    check("len_exp_sample", sample_out, 0);

    ff1b_d = 8'h55; ff1b_wr = 1; len_tick = 1; step();
    ff1b_wr = 0; len_tick = 0;
    check("wr_wins", dut.len_cnt, 8'h55);
    len_tick = 1; step(); len_tick = 0;
    check("tick_inc", dut.len_cnt, 8'h56);

    ff1b_d = 8'hFF; ff1b_wr = 1; step(); ff1b_wr = 0;
    trig = 1; step(); trig = 0;
    step();
    trig = 1; len_tick = 1; step();
    trig = 0; len_tick = 0;
    check("trig_wins_active", ch3_active, 1);
    check("trig_wins_len", dut.len_cnt, 8'h00);
    step();
    check("retrig_play", ch3_active, 1);

    repeat (8) step();
    check("pre_rst_addr", wave_addr, 2);
    check("pre_rst_sample", sample_out, 4'hF);
    #2 rst_n = 0;
    #1;
    check("mid_rst_active", ch3_active, 0);
    check("mid_rst_sample", sample_out, 0);
    check("mid_rst_addr", wave_addr, 0);
    check("mid_rst_nfreq", nfreq_cnt, 11'h7FF);
    step();
    rst_n = 1;
    step(); step();
    check("post_rst_idle", ch3_active, 0);
    trig = 1; step(); trig = 0;
    check("post_rst_trig", ch3_active, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
